// File: rtl/sonar_pkg.sv
// ----------------------------------------------------------------------------
// sonar_pkg
// Shared definitions for the sonar channel scheduler.
//   sonar_state_e : scheduler FSM state encoding (also exported for debug)
//   MEAS_WIDTH    : width of the reported echo measurement in microseconds
//   TIMEOUT_CODE  : measurement value reported when no echo rise was seen
//   us_div()      : clocks per microsecond for a given clock frequency
//   US_DIV        : clocks per microsecond at the default 60 MHz clock
// ----------------------------------------------------------------------------
package sonar_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_TRIG      = 3'd1,
      ST_WAIT_RISE = 3'd2,
      ST_MEASURE   = 3'd3,
      ST_GAP       = 3'd4
   } sonar_state_e;

   localparam int unsigned MEAS_WIDTH = 16;
   localparam logic [MEAS_WIDTH-1:0] TIMEOUT_CODE = 16'hFFFF;

   localparam int unsigned DEFAULT_CLK_FREQUENCY = 60_000_000;

   // The clock frequency is an integer multiple of 1 MHz, so the
   // division is exact.
   function automatic int unsigned us_div(input int unsigned clk_frequency);
      return clk_frequency / 1_000_000;
   endfunction

   localparam int unsigned US_DIV = us_div(DEFAULT_CLK_FREQUENCY);

endpackage

// File: rtl/sonar_us_tick.sv
// ----------------------------------------------------------------------------
// sonar_us_tick
// Microsecond prescaler: emits a one-clock tick every DIV clocks.
//   clk_i     : system clock
//   reset_ni  : asynchronous active-low reset
//   clear_i   : synchronous clear; restarts the DIV-clock period
//   tick_o    : high for one clock at the end of each DIV-clock period
// After a clear the first tick appears DIV clocks later, so every interval
// timed from a clear is an exact multiple of DIV.
// ----------------------------------------------------------------------------
module sonar_us_tick
   import sonar_pkg::*;
#(
   parameter int unsigned DIV = US_DIV
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic clear_i,
   output logic tick_o
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      if (clear_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/sonar_sched.sv
// ----------------------------------------------------------------------------
// sonar_sched
// Round-robin scheduler for ultrasonic trig/echo sonar channels. Fires one
// channel at a time, measures the echo pulse width in microseconds and
// reports it with a one-clock strobe.
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   enable       : per-channel enable mask, sampled only while idle
//   sonar_trig   : trigger pins, at most one bit high
//   sonar_echo   : raw asynchronous echo pins
//   meas_valid   : one-clock strobe when a result is ready
//   meas_chan    : channel index of the last result
//   meas_us      : echo width in microseconds of the last result
//   meas_timeout : last result was a timeout
//   dbg_state    : current scheduler state
// Result fields are registered and hold until the next result.
// ----------------------------------------------------------------------------
module sonar_sched
   import sonar_pkg::*;
#(
   parameter int unsigned CLK_FREQUENCY = 60_000_000,
   parameter int unsigned NUM_SONAR     = 2,
   parameter int unsigned TRIG_US       = 10,
   parameter int unsigned TIMEOUT_US    = 30_000,
   parameter int unsigned GAP_US        = 10_000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_SONAR-1:0]  enable,
   output logic [NUM_SONAR-1:0]  sonar_trig,
   input  logic [NUM_SONAR-1:0]  sonar_echo,
   output logic                  meas_valid,
   output logic [2:0]            meas_chan,
   output logic [MEAS_WIDTH-1:0] meas_us,
   output logic                  meas_timeout,
   output sonar_state_e          dbg_state
);

   localparam int unsigned DIV = us_div(CLK_FREQUENCY);

   // A state ends on the tick that completes its last microsecond.
   localparam logic [MEAS_WIDTH-1:0] TRIG_LAST   = MEAS_WIDTH'(TRIG_US - 1);
   localparam logic [MEAS_WIDTH-1:0] TO_LAST     = MEAS_WIDTH'(TIMEOUT_US - 1);
   localparam logic [MEAS_WIDTH-1:0] GAP_LAST    = MEAS_WIDTH'(GAP_US - 1);
   localparam logic [MEAS_WIDTH-1:0] TIMEOUT_VAL = MEAS_WIDTH'(TIMEOUT_US);

   // ---------------------------------------------------------------------
   // Echo synchroniser (2 flops) and edge detector (1 flop).
   // Pin change to FSM reaction is 3 clocks.
   // ---------------------------------------------------------------------
   logic [NUM_SONAR-1:0] sync1_q;
   logic [NUM_SONAR-1:0] sync2_q;
   logic [NUM_SONAR-1:0] echo_dly_q;
   logic [NUM_SONAR-1:0] echo_rise;
   logic [NUM_SONAR-1:0] echo_fall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         echo_dly_q <= '0;
      end else begin
         sync1_q    <= sonar_echo;
         sync2_q    <= sync1_q;
         echo_dly_q <= sync2_q;
      end
   end

   assign echo_rise = sync2_q & ~echo_dly_q;
   assign echo_fall = ~sync2_q & echo_dly_q;

   // ---------------------------------------------------------------------
   // State and registers
   // ---------------------------------------------------------------------
   sonar_state_e          state_q, state_d;
   logic [2:0]            ch_q, ch_d;           // channel being served / last served
   logic [MEAS_WIDTH-1:0] us_cnt_q, us_cnt_d;
   logic [NUM_SONAR-1:0]  trig_q, trig_d;
   logic                  valid_q, valid_d;
   logic [2:0]            chan_q, chan_d;
   logic [MEAS_WIDTH-1:0] us_q, us_d;
   logic                  to_q, to_d;

   logic                  tick;
   logic                  clear;
   logic [MEAS_WIDTH-1:0] us_next;
   logic                  sel_rise;
   logic                  sel_fall;
   logic [2:0]            pick_ch;

   // Prescaler restarts on every state change so each state's duration
   // is counted from a fresh microsecond boundary.
   sonar_us_tick #(
      .DIV(DIV)
   ) u_us_tick (
      .clk_i   (clk),
      .reset_ni(reset_n),
      .clear_i (clear),
      .tick_o  (tick)
   );

   // Only the served channel's echo edges are visible to the FSM.
   always_comb begin
      sel_rise = 1'b0;
      sel_fall = 1'b0;
      for (int i = 0; i < int'(NUM_SONAR); i++) begin
         if (ch_q == 3'(i)) begin
            sel_rise = echo_rise[i];
            sel_fall = echo_fall[i];
         end
      end
   end

   // Round robin: lowest enabled channel above the last served one,
   // otherwise wrap to the lowest enabled channel. Descending scan so the
   // final assignment is the lowest match.
   always_comb begin
      logic [2:0] first_any;
      logic [2:0] first_after;
      logic       found_after;
      first_any   = '0;
      first_after = '0;
      found_after = 1'b0;
      for (int j = int'(NUM_SONAR) - 1; j >= 0; j--) begin
         if (enable[j]) begin
            first_any = 3'(j);
            if (3'(j) > ch_q) begin
               first_after = 3'(j);
               found_after = 1'b1;
            end
         end
      end
      pick_ch = found_after ? first_after : first_any;
   end

   // Microsecond count including a tick landing on the current clock.
   assign us_next = us_cnt_q + (tick ? MEAS_WIDTH'(1) : MEAS_WIDTH'(0));

   // Next-state and result logic
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      valid_d = 1'b0;
      chan_d  = chan_q;
      us_d    = us_q;
      to_d    = to_q;
      case (state_q)
         ST_IDLE: begin
            if (|enable) begin
               ch_d    = pick_ch;
               state_d = ST_TRIG;
            end
         end
         ST_TRIG: begin
            if (tick && (us_cnt_q == TRIG_LAST)) begin
               state_d = ST_WAIT_RISE;
            end
         end
         ST_WAIT_RISE: begin
            if (sel_rise) begin
               state_d = ST_MEASURE;
            end else if (tick && (us_cnt_q == TO_LAST)) begin
               valid_d = 1'b1;
               chan_d  = ch_q;
               us_d    = TIMEOUT_CODE;
               to_d    = 1'b1;
               state_d = ST_GAP;
            end
         end
         ST_MEASURE: begin
            if (tick && (us_cnt_q == TO_LAST)) begin
               valid_d = 1'b1;
               chan_d  = ch_q;
               us_d    = TIMEOUT_VAL;
               to_d    = 1'b1;
               state_d = ST_GAP;
            end else if (sel_fall) begin
               valid_d = 1'b1;
               chan_d  = ch_q;
               us_d    = us_next;
               to_d    = 1'b0;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (tick && (us_cnt_q == GAP_LAST)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign clear = (state_d != state_q);

   always_comb begin
      if (clear || (state_q == ST_IDLE)) begin
         us_cnt_d = '0;
      end else begin
         us_cnt_d = us_next;
      end
   end

   // Trigger is driven from the next state so it is high for exactly the
   // clocks spent in TRIG.
   always_comb begin
      trig_d = '0;
      for (int i = 0; i < int'(NUM_SONAR); i++) begin
         trig_d[i] = (state_d == ST_TRIG) && (ch_d == 3'(i));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         ch_q     <= 3'(NUM_SONAR - 1);   // first pick lands on channel 0
         us_cnt_q <= '0;
         trig_q   <= '0;
         valid_q  <= 1'b0;
         chan_q   <= '0;
         us_q     <= '0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         us_cnt_q <= us_cnt_d;
         trig_q   <= trig_d;
         valid_q  <= valid_d;
         chan_q   <= chan_d;
         us_q     <= us_d;
         to_q     <= to_d;
      end
   end

   assign sonar_trig   = trig_q;
   assign meas_valid   = valid_q;
   assign meas_chan    = chan_q;
   assign meas_us      = us_q;
   assign meas_timeout = to_q;
   assign dbg_state    = state_q;

endmodule
